// File: rtl/level_config_ctrl.sv
// Difficulty-level selector for the Saper board: qualifies level buttons and holds the board geometry until restart.
// Optional macro LEVEL_RESELECT_EN allows re-selecting a different level while a configuration is active.
module level_config_ctrl #(
   parameter int NUM_LEVELS  = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int CENTER_X    = 720,
   parameter int CENTER_Y    = 450,
   parameter logic [5*NUM_LEVELS-1:0] GRID_TBL  = {5'd16, 5'd10, 5'd8},
   parameter logic [7*NUM_LEVELS-1:0] CELL_TBL  = {7'd40, 7'd50, 7'd50},
   parameter logic [6*NUM_LEVELS-1:0] MINES_TBL = {6'd50, 6'd20, 6'd8}
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_LEVELS-1:0]             btn_sel,
   input  logic                              game_restart,
   output logic [$clog2(NUM_LEVELS+1)-1:0]   level,
   output logic [5:0]                        mines,
   output logic [4:0]                        button_num,
   output logic [6:0]                        button_size,
   output logic [9:0]                        board_size,
   output logic [10:0]                       board_xpos,
   output logic [10:0]                       board_ypos,
   output logic                              cfg_valid,
   output logic                              level_enable
);

   localparam int LW = $clog2(NUM_LEVELS + 1);
   localparam int CW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, QUALIFY, LOAD, ACTIVE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [LW-1:0]   cand, cand_n;
   logic [LW-1:0]   dec;

   logic [4:0]      tbl_grid;
   logic [6:0]      tbl_cell;
   logic [5:0]      tbl_mines;
   logic [11:0]     prod12;

   logic [LW-1:0]   level_n;
   logic [5:0]      mines_n;
   logic [4:0]      button_num_n;
   logic [6:0]      button_size_n;
   logic [9:0]      board_size_n;
   logic [10:0]     board_xpos_n;
   logic [10:0]     board_ypos_n;
   logic            cfg_valid_n;
   logic            level_enable_n;

   // Highest pressed button wins; no button decodes to level 0.
   always_comb begin
      dec = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         if (btn_sel[i]) dec = LW'(i + 1);
      end
   end

   // Table lookup for the candidate level; the product is kept at 12 bits so overflow can be flagged.
   always_comb begin
      int idx;
      idx       = (cand == '0) ? 0 : int'(cand) - 1;
      tbl_grid  = GRID_TBL[5*idx +: 5];
      tbl_cell  = CELL_TBL[7*idx +: 7];
      tbl_mines = MINES_TBL[6*idx +: 6];
      prod12    = {7'b0, tbl_grid} * {5'b0, tbl_cell};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cand  <= cand_n;
      end
   end

   // Next-state logic; a failed shadow qualification falls back to the held configuration.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cand_n  = cand;
      case (state)
         IDLE: begin
            if (dec != '0) begin
               cand_n  = dec;
               cnt_n   = CW'(1);
               state_n = (HOLD_CYCLES == 1) ? LOAD : QUALIFY;
            end
         end
         QUALIFY: begin
            if (dec == cand) begin
               cnt_n = cnt + CW'(1);
               if (cnt == CW'(HOLD_CYCLES - 1)) state_n = LOAD;
            end else begin
               cnt_n   = '0;
               state_n = cfg_valid ? ACTIVE : IDLE;
            end
         end
         LOAD: begin
            cnt_n   = '0;
            state_n = ACTIVE;
         end
         ACTIVE: begin
`ifdef LEVEL_RESELECT_EN
            if (dec != '0 && dec != level) begin
               cand_n  = dec;
               cnt_n   = CW'(1);
               state_n = (HOLD_CYCLES == 1) ? LOAD : QUALIFY;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
      if (game_restart) begin
         state_n = IDLE;
         cnt_n   = '0;
         cand_n  = '0;
      end
   end

   // Output next values: restart clears, LOAD captures the table entry, otherwise hold.
   always_comb begin
      level_n        = level;
      mines_n        = mines;
      button_num_n   = button_num;
      button_size_n  = button_size;
      board_size_n   = board_size;
      board_xpos_n   = board_xpos;
      board_ypos_n   = board_ypos;
      cfg_valid_n    = cfg_valid;
      level_enable_n = 1'b0;
      if (game_restart) begin
         level_n       = '0;
         mines_n       = '0;
         button_num_n  = '0;
         button_size_n = '0;
         board_size_n  = '0;
         board_xpos_n  = '0;
         board_ypos_n  = '0;
         cfg_valid_n   = 1'b0;
      end else if (state == LOAD) begin
         level_n        = cand;
         mines_n        = tbl_mines;
         button_num_n   = tbl_grid;
         button_size_n  = tbl_cell;
         board_size_n   = prod12[9:0];
         board_xpos_n   = 11'(CENTER_X) - {2'b00, prod12[9:1]};
         board_ypos_n   = 11'(CENTER_Y) - {2'b00, prod12[9:1]};
         cfg_valid_n    = 1'b1;
         level_enable_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level        <= '0;
         mines        <= '0;
         button_num   <= '0;
         button_size  <= '0;
         board_size   <= '0;
         board_xpos   <= '0;
         board_ypos   <= '0;
         cfg_valid    <= 1'b0;
         level_enable <= 1'b0;
      end else begin
         level        <= level_n;
         mines        <= mines_n;
         button_num   <= button_num_n;
         button_size  <= button_size_n;
         board_size   <= board_size_n;
         board_xpos   <= board_xpos_n;
         board_ypos   <= board_ypos_n;
         cfg_valid    <= cfg_valid_n;
         level_enable <= level_enable_n;
      end
   end

   // Table entries whose board would not fit in 10 bits are a configuration error.
   always_ff @(posedge clk) begin
      if (!rst && state == LOAD) begin
         assert (prod12 <= 12'd1023)
            else $error("level_config_ctrl: board size %0d exceeds 1023", prod12);
      end
   end

endmodule

// File: tb/tb_level_config_ctrl.sv
// Directed bench for level_config_ctrl: hand-computed geometry per level, qualification latency, restart and reset.
module tb_level_config_ctrl;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  btn_sel;
   logic        game_restart;
   logic [1:0]  level;
   logic [5:0]  mines;
   logic [4:0]  button_num;
   logic [6:0]  button_size;
   logic [9:0]  board_size;
   logic [10:0] board_xpos;
   logic [10:0] board_ypos;
   logic        cfg_valid;
   logic        level_enable;

   int testCount = 0;
   int failCount = 0;

   level_config_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .btn_sel      (btn_sel),
      .game_restart (game_restart),
      .level        (level),
      .mines        (mines),
      .button_num   (button_num),
      .button_size  (button_size),
      .board_size   (board_size),
      .board_xpos   (board_xpos),
      .board_ypos   (board_ypos),
      .cfg_valid    (cfg_valid),
      .level_enable (level_enable)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Drive buttons at the falling edge and let the given number of rising edges pass.
   task automatic applyStimulus(input logic [2:0] btn, input int cycles);
      btn_sel = btn;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic pulseRestart();
      game_restart = 1'b1;
      @(negedge clk);
      game_restart = 1'b0;
   endtask

   task automatic checkConfig(input string tag, input int lvl, input int mn, input int num,
                              input int sz, input int brd, input int x, input int y,
                              input int valid, input int en);
      checkOutput({tag, ".level"}, 32'(level), 32'(lvl));
      checkOutput({tag, ".mines"}, 32'(mines), 32'(mn));
      checkOutput({tag, ".button_num"}, 32'(button_num), 32'(num));
      checkOutput({tag, ".button_size"}, 32'(button_size), 32'(sz));
      checkOutput({tag, ".board_size"}, 32'(board_size), 32'(brd));
      checkOutput({tag, ".xpos"}, 32'(board_xpos), 32'(x));
      checkOutput({tag, ".ypos"}, 32'(board_ypos), 32'(y));
      checkOutput({tag, ".cfg_valid"}, 32'(cfg_valid), 32'(valid));
      checkOutput({tag, ".level_enable"}, 32'(level_enable), 32'(en));
   endtask

   task automatic checkCleared(input string tag);
      checkConfig(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst          = 1'b1;
      btn_sel      = '0;
      game_restart = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkCleared("reset");

      // Level 1: pulse only after HOLD+1 edges
      applyStimulus(3'b001, HOLD);
      checkOutput("l1.noearly_en", 32'(level_enable), 0);
      checkOutput("l1.noearly_valid", 32'(cfg_valid), 0);
      applyStimulus(3'b001, 1);
      checkConfig("l1", 1, 8, 8, 50, 400, 520, 250, 1, 1);
      applyStimulus(3'b000, 1);
      checkConfig("l1.hold", 1, 8, 8, 50, 400, 520, 250, 1, 0);
      pulseRestart();
      checkCleared("l1.restart");

      // Two buttons: highest level wins
      applyStimulus(3'b110, HOLD + 1);
      checkConfig("l3", 3, 50, 16, 40, 640, 400, 130, 1, 1);
      applyStimulus(3'b000, 1);
      checkOutput("l3.en_drop", 32'(level_enable), 0);
      pulseRestart();
      checkCleared("l3.restart");

      // Short press is rejected, full press loads level 2
      applyStimulus(3'b010, HOLD - 1);
      applyStimulus(3'b000, 1);
      checkOutput("short.en", 32'(level_enable), 0);
      checkOutput("short.valid", 32'(cfg_valid), 0);
      applyStimulus(3'b000, 2);
      checkOutput("short.late_valid", 32'(cfg_valid), 0);
      applyStimulus(3'b010, HOLD);
      checkOutput("l2.noearly_en", 32'(level_enable), 0);
      applyStimulus(3'b010, 1);
      checkConfig("l2", 2, 20, 10, 50, 500, 470, 200, 1, 1);

`ifndef LEVEL_RESELECT_EN
      // Buttons ignored while active
      for (int i = 0; i < 10; i++) begin
         applyStimulus(3'b001, 1);
         checkConfig("l2.ignore", 2, 20, 10, 50, 500, 470, 200, 1, 0);
      end
`endif
      applyStimulus(3'b000, 0);
      pulseRestart();
      checkCleared("l2.restart");
      applyStimulus(3'b001, HOLD + 1);
      checkConfig("l1.again", 1, 8, 8, 50, 400, 520, 250, 1, 1);
      pulseRestart();
      checkCleared("l1.again_restart");

      // Reset during qualification restarts the hold count
      applyStimulus(3'b001, 2);
      rst = 1'b1;
      applyStimulus(3'b001, 1);
      checkCleared("rst_qual");
      rst = 1'b0;
      applyStimulus(3'b001, HOLD);
      checkOutput("rst_qual.noearly_en", 32'(level_enable), 0);
      checkOutput("rst_qual.noearly_valid", 32'(cfg_valid), 0);
      applyStimulus(3'b001, 1);
      checkConfig("rst_qual.load", 1, 8, 8, 50, 400, 520, 250, 1, 1);

      // Reset while active
      applyStimulus(3'b000, 1);
      rst = 1'b1;
      applyStimulus(3'b000, 1);
      checkCleared("rst_active");
      rst = 1'b0;
      applyStimulus(3'b000, 1);
      checkCleared("rst_active.after");

      // Restart on the LOAD edge suppresses the pulse
      applyStimulus(3'b001, HOLD);
      btn_sel = 3'b000;
      pulseRestart();
      checkCleared("restart_on_load");
      applyStimulus(3'b000, 2);
      checkCleared("restart_on_load.after");

`ifdef LEVEL_RESELECT_EN
      // Re-selection while active keeps the old config until the new one loads
      applyStimulus(3'b001, HOLD + 1);
      checkConfig("rs.l1", 1, 8, 8, 50, 400, 520, 250, 1, 1);
      applyStimulus(3'b001, 3);
      checkConfig("rs.same", 1, 8, 8, 50, 400, 520, 250, 1, 0);
      for (int i = 0; i < HOLD; i++) begin
         applyStimulus(3'b100, 1);
         checkConfig("rs.shadow", 1, 8, 8, 50, 400, 520, 250, 1, 0);
      end
      applyStimulus(3'b100, 1);
      checkConfig("rs.l3", 3, 50, 16, 40, 640, 400, 130, 1, 1);
      applyStimulus(3'b100, 1);
      checkConfig("rs.l3hold", 3, 50, 16, 40, 640, 400, 130, 1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
